cell_array_ctrl: RTL

Upstream sequencer for a bank of single-bit pass-transistor memory cells, each with Write, Data, Read and Q pins, organised as ROWS words of WIDTH cells. It accepts one read or write request at a time through a valid/ready port. It generates per-row Write/Read strobes and a shared Data bus with the setup/pulse/hold spacing the dynamic cells need, then captures the row's Q outputs into a registered response. It isolates the clocked system from the strobe-timing rules of the cell array.

---
 rtl/cell_array_pkg.sv | 22 ++
 rtl/cell_array_ctrl_row_decoder.sv | 21 ++
 rtl/cell_array_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/cell_array_pkg.sv
// Shared types and constants for the pass-transistor cell array sequencer.
// Imported by the controller and its row decoder.
package cell_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int ROWS_DEF  = 8;
    localparam int WIDTH_DEF = 4;

    // Phase counter must count 0..max(setup,pulse)-1; never narrower than 1 bit.
    function automatic int phase_w(input int s, input int p);
        int m;
        m = (s > p) ? s : p;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cell_array_ctrl_row_decoder.sv
// Address to one-hot row strobe decoder with enable and range flag.
// Shared by the write and read strobe paths.
module row_decoder #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [ROWS-1:0]   onehot,
    output logic              oor
);

    localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

    assign oor = ({1'b0, addr} >= ROWS_L);

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign onehot[i] = en && (addr == ADDR_W'(i));
    end

endmodule

// File: rtl/cell_array_ctrl.sv
// Sequencer generating setup/pulse/hold strobe timing for a dynamic
// cell array, with a single valid/ready request port and registered response.
module cell_array_ctrl
    import cell_array_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [ROWS-1:0]   cell_write,
    output logic [ROWS-1:0]   cell_read,
    output logic [WIDTH-1:0]  cell_data,
    input  logic [WIDTH-1:0]  cell_q
);

    localparam int PW = phase_w(SETUP_CYC, PULSE_CYC);

    state_t            state;
    logic [PW-1:0]     phase;
    logic              alive;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WIDTH-1:0]  wdata_r;
    logic [ROWS-1:0]   rows;
    logic              oor;
    logic              accept;
    logic              last;
    logic              sample;

    // alive keeps ready low until the first edge after reset release
    assign req_ready = alive && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign sample    = (state == PULSE) && last;

    always_comb begin
        last = 1'b0;
        unique case (state)
            SETUP:   last = (phase == PW'(SETUP_CYC - 1));
            PULSE:   last = (phase == PW'(PULSE_CYC - 1));
            HOLD:    last = 1'b1;
            default: last = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            phase   <= '0;
            alive   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else begin
            alive <= 1'b1;
            if (accept) begin
                state   <= SETUP;
                phase   <= '0;
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end else if (state != IDLE) begin
                if (last) begin
                    phase <= '0;
                    unique case (state)
                        SETUP:   state <= PULSE;
                        PULSE:   state <= HOLD;
                        default: state <= IDLE;
                    endcase
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= sample;
            if (sample) begin
                rsp_err   <= oor;
                rsp_rdata <= (we_r || oor) ? '0 : cell_q;
            end
        end
    end

    row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr   (addr_r),
        .en     (state == PULSE),
        .onehot (rows),
        .oor    (oor)
    );

    // Outputs decode from state so reset clears them without waiting for Clk
    assign cell_write = we_r ? rows : '0;
    assign cell_read  = we_r ? '0 : rows;
    assign cell_data  = (we_r && state != IDLE) ? wdata_r : '0;

endmodule
